// File: rtl/dbg_pkg.sv
// Shared types and constants for the regfile debug port.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dbg_pkg;

    localparam int DATA_W_D = 32;
    localparam int ADDR_W_D = 5;

    // VERIFY is only entered when DBG_READBACK_EN is defined
    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ACCESS,
        VERIFY,
        RESP
    } dbgState_t;

    // Channel index width; a single channel still needs one bit
    function automatic int chWidth(input int numCh);
        return (numCh <= 1) ? 1 : $clog2(numCh);
    endfunction

endpackage

// File: rtl/snoop_fifo.sv
// Small circular FIFO with clear and a sticky overflow flag.
// Latency: pushed entry visible at the head one cycle after the push.
// Backpressure: push while full is dropped (sets overflow) unless a pop happens the same cycle.
module snoop_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             clr,
    output logic [WIDTH-1:0] popData,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    // A pop on an empty FIFO is ignored; a pop frees a slot for a same-cycle push
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    // Pointer, occupancy and overflow update; clear outranks push and pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (doPop && !doPush) begin
                count <= count - (PTR_W+1)'(1);
            end
            if (push && !doPush) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_dbg_port.sv
// Debug access to the regfile: halts the CPU, serves one channel read/write, snoops CPU writes (option DBG_READBACK_EN).
// Latency: t_req -> t_gnt 2 cycles, t_gnt -> t_rvalid 2 cycles (writes 3 with DBG_READBACK_EN).
// Backpressure: requesters hold t_req until t_gnt; snoop drops pushes when full and flags s_overflow.
module regfile_dbg_port
    import dbg_pkg::*;
#(
    parameter int DATA_W      = DATA_W_D,
    parameter int ADDR_W      = ADDR_W_D,
    parameter int NUM_CH      = 2,
    parameter int SNOOP_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       p_we,
    input  logic [ADDR_W-1:0]          p_wreg,
    input  logic [ADDR_W-1:0]          p_rega,
    input  logic [ADDR_W-1:0]          p_regb,
    input  logic [DATA_W-1:0]          p_wdata,
    output logic                       proc_stall,
    output logic                       r_we,
    output logic [ADDR_W-1:0]          r_wreg,
    output logic [ADDR_W-1:0]          r_rega,
    output logic [ADDR_W-1:0]          r_regb,
    output logic [DATA_W-1:0]          r_wdata,
    input  logic [DATA_W-1:0]          r_rdata_a,
    input  logic [NUM_CH-1:0]          t_req,
    input  logic [NUM_CH-1:0]          t_we,
    input  logic [NUM_CH*ADDR_W-1:0]   t_reg,
    input  logic [NUM_CH*DATA_W-1:0]   t_wdata,
    output logic [NUM_CH-1:0]          t_gnt,
    output logic                       t_rvalid,
    output logic [DATA_W-1:0]          t_rdata,
    output logic [chWidth(NUM_CH)-1:0] t_rch,
`ifdef DBG_READBACK_EN
    output logic                       t_mismatch,
`endif
    output logic                       s_valid,
    output logic [ADDR_W-1:0]          s_reg,
    output logic [DATA_W-1:0]          s_data,
    input  logic                       s_ready,
    input  logic                       s_clr,
    output logic                       s_overflow
);

    localparam int CH_W    = chWidth(NUM_CH);
    localparam int SNOOP_W = ADDR_W + DATA_W;

    dbgState_t         state;
    dbgState_t         stateNext;
    logic [CH_W-1:0]   lastCh;
    logic [CH_W-1:0]   winCh;
    logic              winVld;
    logic              winWe;
    logic [ADDR_W-1:0] winReg;
    logic [DATA_W-1:0] winWdata;
    logic [NUM_CH-1:0] winOneHot;
    logic [CH_W-1:0]   latCh;
    logic              latWe;
    logic [ADDR_W-1:0] latReg;
    logic [DATA_W-1:0] latWdata;
    logic [DATA_W-1:0] respData;
    logic              snoopPush;
    logic              snoopEmpty;
    logic              unusedFull;
    logic [SNOOP_W-1:0] snoopHead;

    // Round-robin: first requester above the last grant wins, else wrap to the lowest
    always_comb begin
        winVld = 1'b0;
        winCh  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!winVld && t_req[i] && (i > int'(lastCh))) begin
                winVld = 1'b1;
                winCh  = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!winVld && t_req[i] && (i <= int'(lastCh))) begin
                winVld = 1'b1;
                winCh  = CH_W'(i);
            end
        end
    end

    // Pick the winning channel's command fields and grant vector
    always_comb begin
        winWe     = 1'b0;
        winReg    = '0;
        winWdata  = '0;
        winOneHot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == winCh) begin
                winWe        = t_we[i];
                winReg       = t_reg[i*ADDR_W +: ADDR_W];
                winWdata     = t_wdata[i*DATA_W +: DATA_W];
                winOneHot[i] = winVld;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state; HALT falls back to IDLE if every request was withdrawn
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   stateNext = (|t_req) ? HALT : IDLE;
            HALT:   stateNext = winVld ? ACCESS : IDLE;
`ifdef DBG_READBACK_EN
            ACCESS: stateNext = latWe ? VERIFY : RESP;
`else
            ACCESS: stateNext = RESP;
`endif
            VERIFY: stateNext = RESP;
            RESP:   stateNext = (|t_req) ? HALT : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign proc_stall = (state != IDLE);

    // Writes to r0 have no effect, so their response reports the bus readback instead
`ifdef DBG_READBACK_EN
    assign respData = r_rdata_a;
`else
    assign respData = (latWe && (latReg != '0)) ? latWdata : r_rdata_a;
`endif

    // Latch the granted command in HALT and register the response at the end of RESP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastCh   <= '0;
            latCh    <= '0;
            latWe    <= 1'b0;
            latReg   <= '0;
            latWdata <= '0;
            t_gnt    <= '0;
            t_rvalid <= 1'b0;
            t_rdata  <= '0;
            t_rch    <= '0;
        end else begin
            t_gnt    <= '0;
            t_rvalid <= 1'b0;
            if ((state == HALT) && winVld) begin
                lastCh   <= winCh;
                latCh    <= winCh;
                latWe    <= winWe;
                latReg   <= winReg;
                latWdata <= winWdata;
                t_gnt    <= winOneHot;
            end
            if (state == RESP) begin
                t_rvalid <= 1'b1;
                t_rch    <= latCh;
                t_rdata  <= respData;
            end
        end
    end

`ifdef DBG_READBACK_EN
    // Flag a write whose readback differs from the data written
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t_mismatch <= 1'b0;
        end else begin
            t_mismatch <= (state == RESP) && latWe && (r_rdata_a != latWdata);
        end
    end
`endif

    // Regfile mux: processor owns the bus in IDLE/HALT, the latched command otherwise
    always_comb begin
        r_we    = p_we;
        r_wreg  = p_wreg;
        r_rega  = p_rega;
        r_regb  = p_regb;
        r_wdata = p_wdata;
        case (state)
            ACCESS: begin
                r_we    = latWe;
                r_wreg  = latWe ? latReg : '0;
                r_wdata = latWe ? latWdata : '0;
                r_rega  = latWe ? '0 : latReg;
                r_regb  = '0;
            end
            VERIFY, RESP: begin
                r_we    = 1'b0;
                r_wreg  = '0;
                r_wdata = '0;
                r_rega  = latReg;
                r_regb  = '0;
            end
            default: ;
        endcase
    end

    // Only processor writes to a real register while it owns the bus are traced
    assign snoopPush = p_we && (p_wreg != '0) && ((state == IDLE) || (state == HALT));

    snoop_fifo #(
        .WIDTH (SNOOP_W),
        .DEPTH (SNOOP_DEPTH)
    ) uSnoop (
        .clock    (clock),
        .reset    (reset),
        .push     (snoopPush),
        .pushData ({p_wreg, p_wdata}),
        .pop      (s_ready),
        .clr      (s_clr),
        .popData  (snoopHead),
        .empty    (snoopEmpty),
        .full     (unusedFull),
        .overflow (s_overflow)
    );

    assign s_valid = !snoopEmpty;
    assign s_reg   = snoopHead[SNOOP_W-1 -: ADDR_W];
    assign s_data  = snoopHead[DATA_W-1:0];

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed bench for regfile_dbg_port with a behavioural regfile (r0 reads as zero).
// Latency: expected grant/response timing is written per test in cycles after the request.
// Backpressure: snoop FIFO driven through s_ready/s_clr; requesters drop t_req on t_gnt.
module tb_regfile_dbg_port;

    logic        clock;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_wreg, p_rega, p_regb;
    logic [31:0] p_wdata;
    logic        proc_stall;
    logic        r_we;
    logic [4:0]  r_wreg, r_rega, r_regb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_a;
    logic [1:0]  t_req, t_we;
    logic [9:0]  t_reg;
    logic [63:0] t_wdata;
    logic [1:0]  t_gnt;
    logic        t_rvalid;
    logic [31:0] t_rdata;
    logic [0:0]  t_rch;
    logic        s_valid;
    logic [4:0]  s_reg;
    logic [31:0] s_data;
    logic        s_ready, s_clr, s_overflow;
`ifdef DBG_READBACK_EN
    logic        t_mismatch;
    localparam int W_RV = 5;
`else
    localparam int W_RV = 4;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] regs [32];

    regfile_dbg_port dut (
        .clock(clock), .reset(reset),
        .p_we(p_we), .p_wreg(p_wreg), .p_rega(p_rega), .p_regb(p_regb), .p_wdata(p_wdata),
        .proc_stall(proc_stall),
        .r_we(r_we), .r_wreg(r_wreg), .r_rega(r_rega), .r_regb(r_regb), .r_wdata(r_wdata),
        .r_rdata_a(r_rdata_a),
        .t_req(t_req), .t_we(t_we), .t_reg(t_reg), .t_wdata(t_wdata),
        .t_gnt(t_gnt), .t_rvalid(t_rvalid), .t_rdata(t_rdata), .t_rch(t_rch),
`ifdef DBG_READBACK_EN
        .t_mismatch(t_mismatch),
`endif
        .s_valid(s_valid), .s_reg(s_reg), .s_data(s_data),
        .s_ready(s_ready), .s_clr(s_clr), .s_overflow(s_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural regfile: synchronous write, combinational port A read, r0 fixed at zero
    always @(posedge clock) begin
        if (r_we && (r_wreg != 5'd0)) regs[r_wreg] <= r_wdata;
    end
    assign r_rdata_a = (r_rega == 5'd0) ? 32'd0 : regs[r_rega];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    // One channel transaction; latencies are -1 when the bounded wait expires
    task automatic do_txn(input int ch, input logic we, input logic [4:0] rg, input logic [31:0] wd,
                          output logic [31:0] rdata, output int rch, output logic mism,
                          output int gntLat, output int rvLat);
        rdata = 32'hx; rch = -1; mism = 1'bx; gntLat = -1; rvLat = -1;
        t_req[ch] = 1'b1;
        t_we[ch] = we;
        t_reg[ch*5 +: 5] = rg;
        t_wdata[ch*32 +: 32] = wd;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (t_gnt[ch]) begin gntLat = c; break; end
        end
        t_req[ch] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (t_rvalid) begin
                rvLat = c; rdata = t_rdata; rch = int'(t_rch);
`ifdef DBG_READBACK_EN
                mism = t_mismatch;
`else
                mism = 1'b0;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd; int rch, gl, rl; logic mm;
        checks++; if ({proc_stall, t_gnt, t_rvalid, t_rdata, t_rch, s_valid, s_overflow} !== 39'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {proc_stall, t_gnt, t_rvalid, t_rdata, t_rch, s_valid, s_overflow}); end
        reset = 1'b1;
        tick();
        t_req = 2'b01; t_we = 2'b00; t_reg = 10'd7;
        tick(); tick();
        checks++; if (t_gnt !== 2'b01) begin errors++; $display("FAIL pre_abort_gnt: got %b expected 01", t_gnt); end
        reset = 1'b0;
        #1;
        checks++; if ({proc_stall, t_gnt, t_rvalid, t_rdata, t_rch, s_valid, s_overflow} !== 39'd0) begin
            errors++; $display("FAIL abort_outputs: got %h expected 0", {proc_stall, t_gnt, t_rvalid, t_rdata, t_rch, s_valid, s_overflow}); end
        t_req = 2'b00;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if ({t_rvalid, proc_stall} !== 2'b00) begin errors++; $display("FAIL abort_no_resp: got %b expected 00", {t_rvalid, proc_stall}); end
        end
    endtask

    task automatic test_passthrough;
        p_we = 1'b1; p_wreg = 5'd5; p_wdata = 32'hDEADBEEF; p_rega = 5'd3; p_regb = 5'd4;
        #1;
        checks++; if ({r_we, r_wreg, r_rega, r_regb, r_wdata} !== {1'b1, 5'd5, 5'd3, 5'd4, 32'hDEADBEEF}) begin
            errors++; $display("FAIL passthrough: got %h expected %h", {r_we, r_wreg, r_rega, r_regb, r_wdata}, {1'b1, 5'd5, 5'd3, 5'd4, 32'hDEADBEEF}); end
        tick();
        p_we = 1'b0; p_rega = 5'd0; p_regb = 5'd0;
        checks++; if ({s_valid, s_reg, s_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL snoop_head: got %h expected %h", {s_valid, s_reg, s_data}, {1'b1, 5'd5, 32'hDEADBEEF}); end
        s_ready = 1'b1; tick(); s_ready = 1'b0;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL snoop_pop: got %b expected 0", s_valid); end
    endtask

    task automatic test_single_write;
        logic [31:0] rd; int rch, gl, rl; logic mm;
        t_req = 2'b10; t_we = 2'b10; t_reg = {5'd7, 5'd0}; t_wdata = {32'h12345678, 32'h0};
        for (int c = 1; c <= W_RV + 1; c++) begin
            tick();
            checks++; if (proc_stall !== (c < W_RV)) begin errors++; $display("FAIL sw_stall c%0d: got %b expected %b", c, proc_stall, (c < W_RV)); end
            checks++; if (t_gnt !== ((c == 2) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL sw_gnt c%0d: got %b", c, t_gnt); end
            checks++; if (t_rvalid !== (c == W_RV)) begin errors++; $display("FAIL sw_rvalid c%0d: got %b", c, t_rvalid); end
            if (c == W_RV) begin
                checks++; if ({t_rch, t_rdata} !== {1'b1, 32'h12345678}) begin
                    errors++; $display("FAIL sw_resp: got %h expected %h", {t_rch, t_rdata}, {1'b1, 32'h12345678}); end
            end
            if (c == 2) t_req = 2'b00;
        end
        do_txn(1, 1'b0, 5'd7, 32'h0, rd, rch, mm, gl, rl);
        checks++; if ({gl, rl} !== {32'd2, 32'd2}) begin errors++; $display("FAIL rd_latency: got gnt %0d rv %0d expected 2 2", gl, rl); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_r7: got %h expected 12345678", rd); end
        checks++; if (rch !== 1) begin errors++; $display("FAIL rd_rch: got %0d expected 1", rch); end
    endtask

    task automatic test_round_robin;
        t_req = 2'b11; t_we = 2'b00; t_reg = {5'd5, 5'd7};
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++; if (proc_stall !== (c <= 9)) begin errors++; $display("FAIL rr_stall c%0d: got %b", c, proc_stall); end
            checks++; if (t_gnt !== ((c == 2 || c == 8) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL rr_gnt c%0d: got %b", c, t_gnt); end
            checks++; if (t_rvalid !== (c == 4 || c == 7 || c == 10)) begin errors++; $display("FAIL rr_rvalid c%0d: got %b", c, t_rvalid); end
            if (c == 4 || c == 10) begin
                checks++; if ({t_rch, t_rdata} !== {1'b0, 32'h12345678}) begin errors++; $display("FAIL rr_resp c%0d: got %h", c, {t_rch, t_rdata}); end
            end
            if (c == 7) begin
                checks++; if ({t_rch, t_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL rr_resp c%0d: got %h", c, {t_rch, t_rdata}); end
            end
            if (c == 8) t_req = 2'b00;
        end
    endtask

    task automatic test_fifo_overflow;
        for (int k = 0; k < 5; k++) begin
            p_we = 1'b1; p_wreg = 5'(10 + k); p_wdata = 32'hA0 + k;
            tick();
        end
        p_we = 1'b0;
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", s_overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if ({s_valid, s_reg, s_data} !== {1'b1, 5'(10 + k), 32'hA0 + k}) begin
                errors++; $display("FAIL ovf_entry%0d: got %h", k, {s_valid, s_reg, s_data}); end
            s_ready = 1'b1; tick(); s_ready = 1'b0;
        end
        checks++; if ({s_valid, s_overflow} !== 2'b01) begin errors++; $display("FAIL ovf_drained: got %b expected 01", {s_valid, s_overflow}); end
        s_clr = 1'b1; p_we = 1'b1; p_wreg = 5'd20; p_wdata = 32'h20;
        tick();
        s_clr = 1'b0; p_we = 1'b0;
        checks++; if ({s_valid, s_overflow} !== 2'b00) begin errors++; $display("FAIL clr: got %b expected 00", {s_valid, s_overflow}); end
        s_ready = 1'b1; tick(); s_ready = 1'b0;
        p_we = 1'b1; p_wreg = 5'd21; p_wdata = 32'h21;
        tick();
        p_we = 1'b0;
        checks++; if ({s_valid, s_reg, s_data} !== {1'b1, 5'd21, 32'h21}) begin
            errors++; $display("FAIL empty_pop: got %h", {s_valid, s_reg, s_data}); end
        s_ready = 1'b1; tick(); s_ready = 1'b0;
    endtask

    task automatic test_reg0_full;
        logic [31:0] rd; int rch, gl, rl; logic mm;
        do_txn(0, 1'b1, 5'd0, 32'h0000FFFF, rd, rch, mm, gl, rl);
        checks++; if (rl < 0) begin errors++; $display("FAIL r0_timeout: got no response expected one"); end
        checks++; if ({rch, rd} !== {32'd0, 32'd0}) begin errors++; $display("FAIL r0_resp: got ch %0d data %h expected ch 0 data 0", rch, rd); end
        for (int k = 0; k < 4; k++) begin
            p_we = 1'b1; p_wreg = 5'(22 + k); p_wdata = 32'hB0 + k;
            tick();
        end
        checks++; if ({s_valid, s_overflow} !== 2'b10) begin errors++; $display("FAIL full_state: got %b expected 10", {s_valid, s_overflow}); end
        p_wreg = 5'd26; p_wdata = 32'hB4; s_ready = 1'b1;
        tick();
        p_we = 1'b0; s_ready = 1'b0;
        checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b expected 0", s_overflow); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if ({s_valid, s_reg, s_data} !== {1'b1, 5'(22 + k), 32'hB0 + k}) begin
                errors++; $display("FAIL full_entry%0d: got %h", k, {s_valid, s_reg, s_data}); end
            s_ready = 1'b1; tick(); s_ready = 1'b0;
        end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL full_count: got %b expected 0", s_valid); end
    endtask

`ifdef DBG_READBACK_EN
    task automatic test_readback;
        logic [31:0] rd; int rch, gl, rl; logic mm;
        do_txn(0, 1'b1, 5'd3, 32'h0000A5A5, rd, rch, mm, gl, rl);
        checks++; if (rl !== 3) begin errors++; $display("FAIL rb_latency: got %0d expected 3", rl); end
        checks++; if ({mm, rd} !== {1'b0, 32'h0000A5A5}) begin errors++; $display("FAIL rb_r3: got %h expected %h", {mm, rd}, {1'b0, 32'h0000A5A5}); end
        do_txn(0, 1'b1, 5'd0, 32'h1, rd, rch, mm, gl, rl);
        checks++; if ({mm, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rb_r0: got %h expected %h", {mm, rd}, {1'b1, 32'h0}); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset = 1'b0;
        p_we = 1'b0; p_wreg = '0; p_rega = '0; p_regb = '0; p_wdata = '0;
        t_req = '0; t_we = '0; t_reg = '0; t_wdata = '0;
        s_ready = 1'b0; s_clr = 1'b0;
        tick(); tick();
        test_reset();
        test_passthrough();
        test_single_write();
        test_round_robin();
        test_fifo_overflow();
        test_reg0_full();
`ifdef DBG_READBACK_EN
        test_readback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
